// File: rtl/alu_pkg.sv
// Shared ALU opcode package: the operation encodings understood by alu and
// every client that issues work to it.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ALU_ADD  = 4'd0,
        OP_ALU_SUB  = 4'd1,
        OP_ALU_AND  = 4'd2,
        OP_ALU_OR   = 4'd3,
        OP_ALU_XOR  = 4'd4,
        OP_ALU_SLL  = 4'd5,
        OP_ALU_SRL  = 4'd6,
        OP_ALU_SRA  = 4'd7,
        OP_ALU_SLT  = 4'd8,
        OP_ALU_SLTU = 4'd9,
        OP_ALU_EQ   = 4'd10,
        OP_ALU_NEQ  = 4'd11,
        OP_ALU_PC   = 4'd12
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU. Shifts use the low five bits of b; compares
// return 0 or 1; encodings outside the defined set produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    logic [4:0] shamt;

    assign shamt = i_b[4:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ALU_ADD:  o_result = i_a + i_b;
            OP_ALU_SUB:  o_result = i_a - i_b;
            OP_ALU_AND:  o_result = i_a & i_b;
            OP_ALU_OR:   o_result = i_a | i_b;
            OP_ALU_XOR:  o_result = i_a ^ i_b;
            OP_ALU_SLL:  o_result = i_a << shamt;
            OP_ALU_SRL:  o_result = i_a >> shamt;
            OP_ALU_SRA:  o_result = $unsigned($signed(i_a) >>> shamt);
            OP_ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            OP_ALU_EQ:   o_result = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
            OP_ALU_NEQ:  o_result = {{(WIDTH-1){1'b0}}, (i_a != i_b)};
            OP_ALU_PC:   o_result = i_a + WIDTH'(4);
            default:     o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, one
// operation in flight, result held until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  alu_op_t          i_req0_op,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  alu_op_t          i_req1_op,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_id,
    output logic [15:0]      o_ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_id_q, rsp_id_d;
    logic [15:0]      ops_done_q, ops_done_d;

    logic             grant;
    logic [WIDTH-1:0] alu_result;

    // The pointer only breaks ties; a lone requester always wins.
    assign grant = (i_req_valid == 2'b11) ? ptr_q : i_req_valid[1];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        ops_done_d   = ops_done_q;
        o_req_ready  = 2'b00;
        o_rsp_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((i_req_valid != 2'b00) && !i_rst) begin
                    o_req_ready = grant ? 2'b10 : 2'b01;
                    op_d        = grant ? i_req1_op : i_req0_op;
                    a_d         = grant ? i_req1_a  : i_req0_a;
                    b_d         = grant ? i_req1_b  : i_req0_b;
                    id_d        = grant;
                    ptr_d       = ~grant;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_id_d     = id_q;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            op_q         <= OP_ALU_ADD;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            ops_done_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            ops_done_q   <= ops_done_d;
        end
    end

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .i_op    (op_q),
        .i_a     (a_q),
        .i_b     (b_q),
        .o_result(alu_result)
    );

    assign o_rsp_result = rsp_result_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_ops_done   = ops_done_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: i_clk  input  1  the single clock; all state updates on rising edge.
REQ-003 Port: i_rst  input  1  synchronous, active-high reset.
REQ-004 Port: i_req_valid  input  2  per-requester request valid (bit 0 = requester 0, bit 1 = requester 1).
REQ-005 Port: o_req_ready  output  2  per-requester accept; a request is accepted in a cycle where valid and ready are both 1.
REQ-006 Port: i_req0_op / i_req1_op  input  alu_op_t  ALU operation per requester.
REQ-007 Port: i_req0_a, i_req0_b / i_req1_a, i_req1_b  input  WIDTH  operands per requester.
REQ-008 Port: o_rsp_valid  output  1  result available.
REQ-009 Port: i_rsp_ready  input  1  consumer accepts the result when valid and ready are both 1.
REQ-010 Port: o_rsp_result  output  WIDTH  ALU result.
REQ-011 Port: o_rsp_id  output  1  index of the requester that owns o_rsp_result.
REQ-012 Port: o_ops_done  output  16  count of completed responses (handshakes on the response port), wrapping.

Function
REQ-013 The block SHALL share one ALU instance between two requesters, one operation in flight at a time.
REQ-014 FSM states SHALL be IDLE, EXEC, HOLD.
REQ-015 IDLE: o_req_ready SHALL be one-hot to the granted requester when any i_req_valid is 1, else 2'b00; on accept, op/a/b/id SHALL be registered and the FSM SHALL go to EXEC.
REQ-016 EXEC: the ALU SHALL evaluate the registered operands; the result and id SHALL be registered into o_rsp_result/o_rsp_id, and the FSM SHALL go to HOLD.
REQ-017 HOLD: o_rsp_valid SHALL be 1; on i_rsp_ready=1 the FSM SHALL return to IDLE; otherwise o_rsp_result/o_rsp_id SHALL stay stable.
REQ-018 o_req_ready SHALL be 2'b00 in EXEC and HOLD; o_rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-019 Latency: accept in cycle N -> o_rsp_valid=1 in cycle N+2; minimum issue interval is 3 cycles.
REQ-020 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the preferred requester when both are valid; a lone valid requester is granted regardless of the pointer.
REQ-021 On each accept, the pointer SHALL move to the requester not granted.
REQ-022 Requesters SHALL hold valid, op and operands stable until accepted; the block does not sample unaccepted requests.
REQ-023 Arithmetic SHALL follow the shared ALU exactly: shifts use b[4:0], SLT/SLTU/EQ/NEQ return 0 or 1, OP_ALU_PC returns a+4, and undefined ops return 0; all results wrap modulo 2^WIDTH.
REQ-024 o_ops_done SHALL increment by 1 on each response handshake and wrap from 16'hFFFF to 16'h0000.

Reset
REQ-025 While i_rst=1 at a clock edge: FSM -> IDLE, pointer -> requester 0, o_rsp_valid=0, o_rsp_result=0, o_rsp_id=0, o_ops_done=0.
REQ-026 Reset in EXEC or HOLD SHALL discard the in-flight operation without producing a response; o_req_ready SHALL be 2'b00 while i_rst=1.

Structure
REQ-027 alu_op_t and the OP_ALU_* encodings SHALL come from the shared ALU opcode package; no local redefinition.
REQ-028 The block SHALL instantiate the existing alu module (WIDTH passed through) as its only sub-module.
REQ-029 State encoding SHALL be an enum local to the block.

Verification
REQ-030 After reset, req0 ADD a=1 b=1 -> accepted in cycle N; o_rsp_valid=1, result 32'h2, id 0 in cycle N+2.
REQ-031 Both valid after reset (req0 SUB 5-7, req1 AND 0xF0&0x3C) -> req0 served first (32'hFFFFFFFE, id 0), then req1 (32'h30, id 1).
REQ-032 Both valid continuously for 4 operations -> ids alternate 0,1,0,1.
REQ-033 req1 SRA a=32'h80000000 b=4 with i_rsp_ready=0 for 5 cycles -> result 32'hF8000000 stable, o_req_ready=2'b00 throughout, and o_ops_done increments only at release.
REQ-034 Assert i_rst in EXEC -> no response; next cycle o_rsp_valid=0, o_ops_done=0, pointer favors req0.
REQ-035 Preload via 65535 completed operations -> o_ops_done=16'hFFFF; next handshake -> 16'h0000.
